// File: rtl/prime_list.sv
// Self-initialising prime table: a sieve over 2..2^DATA_W-1 is compacted into an
// ordered table after reset, then index selects the n-th prime with one cycle of latency.
//
// state   | meaning
// SCAN    | advance p; start marking multiples of p when flag[p] is still set
// MARK    | clear flag[m] for m = p*p, p*p+p, ... up to 2^DATA_W-1
// COMPACT | copy each surviving candidate c into table[wptr]
// DONE    | table built, ready held high until reset
module prime_list #(
  parameter int DATA_W  = 9,
  parameter int INDEX_W = 13,
  parameter int TABLE_D = 97
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] index,
  output logic               ready,
  output logic [DATA_W-1:0]  data
);

  localparam int FLAG_N = 2 ** DATA_W;
  localparam int TW     = $clog2(TABLE_D + 1);

  localparam logic [DATA_W:0]     MAX_V  = {1'b0, {DATA_W{1'b1}}};
  localparam logic [2*DATA_W+1:0] MAX_PP = {{(DATA_W + 2){1'b0}}, {DATA_W{1'b1}}};
  localparam logic [DATA_W:0]     TWO    = {{(DATA_W - 1){1'b0}}, 2'b10};

  typedef enum logic [1:0] {SCAN, MARK, COMPACT, DONE} state_t;

  state_t              state;
  logic [FLAG_N-1:0]   flags;
  logic [DATA_W:0]     p;
  logic [DATA_W:0]     m;
  logic [DATA_W:0]     c;
  logic [INDEX_W-1:0]  wptr;
  logic [DATA_W-1:0]   tbl [0:TABLE_D];

  logic [2*DATA_W+1:0] pp;
  logic [DATA_W:0]     mp;
  logic                tbl_we;
  logic                idx_ok;

  always_comb begin
    pp     = {{(DATA_W + 1){1'b0}}, p} * {{(DATA_W + 1){1'b0}}, p};
    mp     = m + p;
    tbl_we = (state == COMPACT) && flags[c[DATA_W-1:0]] && (wptr <= INDEX_W'(TABLE_D));
    // full-width range check so high index bits never alias onto a table entry
    idx_ok = (index != '0) && (index <= INDEX_W'(TABLE_D));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SCAN;
      p     <= TWO;
      m     <= '0;
      c     <= '0;
      wptr  <= INDEX_W'(1);
      ready <= 1'b0;
      flags <= {{(FLAG_N - 2){1'b1}}, 2'b00};
    end else begin
      case (state)
        SCAN: begin
          if (pp > MAX_PP) begin
            state <= COMPACT;
            c     <= TWO;
          end else if (flags[p[DATA_W-1:0]]) begin
            m     <= pp[DATA_W:0];
            state <= MARK;
          end else begin
            p <= p + 1'b1;
          end
        end
        MARK: begin
          flags[m[DATA_W-1:0]] <= 1'b0;
          if (mp > MAX_V) begin
            state <= SCAN;
            p     <= p + 1'b1;
          end else begin
            m <= mp;
          end
        end
        COMPACT: begin
          if (tbl_we) wptr <= wptr + 1'b1;
          if (c == MAX_V) begin
            state <= DONE;
            ready <= 1'b1;
          end else begin
            c <= c + 1'b1;
          end
        end
        DONE: ready <= 1'b1;
        default: state <= SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_we) tbl[wptr[TW-1:0]] <= c[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      data <= '0;
    else if (ready && idx_ok)
      data <= tbl[index[TW-1:0]];
    else
      data <= '0;
  end

endmodule

// File: tb/tb_prime_list.sv
// Directed bench for prime_list: reference primes come from trial division and
// are queued when an index is driven, then compared one cycle later.
module tb_prime_list;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] index = 13'd1;
  logic        ready;
  logic [8:0]  data;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int build1, build2, exp_build;

  prime_list dut (
    .clk   (clk),
    .rst_n (rst_n),
    .index (index),
    .ready (ready),
    .data  (data)
  );

  always #5 clk = ~clk;

  function automatic bit is_prime(int v);
    if (v < 2) return 1'b0;
    for (int d = 2; d * d <= v; d++)
      if (v % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int nth_prime(int n);
    int cnt = 0;
    if (n < 1) return 0;
    for (int v = 2; v < 512; v++) begin
      if (is_prime(v)) begin
        cnt++;
        if (cnt == n) return v;
      end
    end
    return 0;
  endfunction

  // one cycle per scan step, one per marked multiple, one per compacted candidate
  function automatic int build_cycles();
    int n = 0;
    for (int p = 2; p < 512; p++) begin
      n++;
      if (p * p > 511) break;
      if (is_prime(p))
        for (int m = p * p; m <= 511; m += p) n++;
    end
    return n + 510;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("reset_ready", {31'd0, ready}, 0);
    check("reset_data", {23'd0, data}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(input bit toggle, output int cycles);
    cycles = 0;
    while (cycles < 1300) begin
      @(posedge clk);
      #1;
      cycles++;
      check("data_during_build", {23'd0, data}, 0);
      if (ready === 1'b1) break;
      if (toggle) index = 13'($urandom_range(0, 8191));
    end
    check("ready_by_1250", {31'd0, (ready === 1'b1) && (cycles <= 1250)}, 1);
  endtask

  task automatic lookup(input int idx);
    @(negedge clk);
    index = idx[12:0];
    exp_q.push_back(nth_prime(idx));
    @(posedge clk);
    #1;
    check($sformatf("lookup_%0d", idx), {23'd0, data}, exp_q.pop_front());
  endtask

  initial begin
    exp_build = build_cycles();

    // build from reset with index held at 1
    do_reset();
    wait_ready(1'b0, build1);
    check("build_cycles", build1, exp_build);
    lookup(1);

    for (int i = 2; i <= 13; i++) begin
      lookup(i);
      repeat (49) @(posedge clk);
    end

    lookup(25);
    lookup(96);
    lookup(97);

    lookup(0);
    lookup(98);
    lookup(13'h1FFF);
    lookup(13'h0081);

    // reset pulsed mid-build, then a full rebuild
    index = 13'd1;
    do_reset();
    repeat (599) @(posedge clk);
    do_reset();
    wait_ready(1'b0, build2);
    check("rebuild_cycles", build2, exp_build);
    for (int i = 1; i <= 13; i++) lookup(i);

    // reset after ready, index churning during the rebuild
    check("ready_before_pulse", {31'd0, ready}, 1);
    do_reset();
    wait_ready(1'b1, build2);
    check("toggle_build_cycles", build2, exp_build);
    lookup(1);
    lookup(50);
    lookup(97);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
